// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer: buffers (command, argument) pairs in a small FIFO and
// serialises each pair into a 6-byte frame HEAD, LEN, code, arg, CHK, TAIL.
// It sends one byte per send_en/tx_down handshake with the UART transmitter
// and leaves an idle gap after each frame.
module uart_cmd_framer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 50000,
  parameter logic [7:0]  HEAD       = 8'h7E,
  parameter logic [7:0]  TAIL       = 8'hEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_code,
  input  logic [7:0] cmd_arg,
  output logic       cmd_ready,
  output logic       send_en,
  output logic [7:0] date_byte,
  input  logic       tx_down,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [7:0]  LEN = 8'h04;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [7:0]    code_q, code_d, arg_q, arg_d, chk_q, chk_d, date_q, date_d;
  logic [2:0]    idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          frame_done_q, frame_done_d;
  logic          fifo_wr, fifo_rd;
  logic [7:0]    head_code, head_arg, next_byte;

  assign cmd_ready  = (count_q != CW'(FIFO_DEPTH));
  assign fifo_wr    = cmd_valid && cmd_ready;
  assign {head_code, head_arg} = mem_q[rd_ptr_q];
  assign send_en    = (state_q == SEND);
  assign busy       = (state_q != IDLE);
  assign date_byte  = date_q;
  assign frame_done = frame_done_q;

  // FIFO storage: written at the write pointer on an accepted request
  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= {cmd_code, cmd_arg};
  end

  // FIFO pointer and occupancy update; simultaneous push and pop keep the count
  always_comb begin
    wr_ptr_d = fifo_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = fifo_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (fifo_wr && !fifo_rd)      count_d = count_q + 1'b1;
    else if (!fifo_wr && fifo_rd) count_d = count_q - 1'b1;
  end

  // Frame byte that follows the current index
  always_comb begin
    case (idx_q)
      3'd0:    next_byte = LEN;
      3'd1:    next_byte = code_q;
      3'd2:    next_byte = arg_q;
      3'd3:    next_byte = chk_q;
      default: next_byte = TAIL;
    endcase
  end

  // Frame sequencer: next state, byte register load, FIFO pop and gap counting.
  // date_byte is loaded on the transition into SEND so it stays put until the next pulse.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    code_d       = code_q;
    arg_d        = arg_q;
    chk_d        = chk_q;
    date_d       = date_q;
    gap_d        = gap_q;
    frame_done_d = 1'b0;
    fifo_rd      = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          fifo_rd = 1'b1;
          code_d  = head_code;
          arg_d   = head_arg;
          chk_d   = LEN + head_code + head_arg;
          idx_d   = '0;
          date_d  = HEAD;
          state_d = SEND;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (tx_down) begin
          if (idx_q == 3'd5) begin
            frame_done_d = 1'b1;
            if (GAP_CYCLES == 0) begin
              state_d = IDLE;
            end else begin
              gap_d   = GW'(GAP_CYCLES);
              state_d = GAP;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            date_d  = next_byte;
            state_d = SEND;
          end
        end
      end
      GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q <= GW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      code_q       <= '0;
      arg_q        <= '0;
      chk_q        <= '0;
      date_q       <= '0;
      idx_q        <= '0;
      gap_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      code_q       <= code_d;
      arg_q        <= arg_d;
      chk_q        <= chk_d;
      date_q       <= date_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Testbench for uart_cmd_framer: one instance with a 20-cycle gap and one
// with no gap, each driven by a transmitter model and checked by a byte scoreboard.
module tb_uart_cmd_framer;

  localparam int unsigned GAP = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid_v [2];
  logic [7:0] cmd_code_v  [2];
  logic [7:0] cmd_arg_v   [2];
  logic       cmd_ready_w [2];
  logic       send_en_w   [2];
  logic [7:0] date_w      [2];
  logic       tx_w        [2];
  logic       busy_w      [2];
  logic       frame_done_w[2];
  logic       tx_model    [2];
  logic       spur        [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int txd_cyc [2];
  int pend    [2];
  int nsend   [2];
  int nframe  [2];
  bit armed   [2];
  bit gap_chk_en = 1'b0;
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign tx_w[0] = tx_model[0] | spur[0];
  assign tx_w[1] = tx_model[1] | spur[1];

  uart_cmd_framer #(.FIFO_DEPTH(4), .GAP_CYCLES(GAP), .HEAD(8'h7E), .TAIL(8'hEF)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_v[0]), .cmd_code(cmd_code_v[0]),
    .cmd_arg(cmd_arg_v[0]), .cmd_ready(cmd_ready_w[0]), .send_en(send_en_w[0]),
    .date_byte(date_w[0]), .tx_down(tx_w[0]), .busy(busy_w[0]), .frame_done(frame_done_w[0])
  );

  uart_cmd_framer #(.FIFO_DEPTH(4), .GAP_CYCLES(0), .HEAD(8'h7E), .TAIL(8'hEF)) dut_g0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_v[1]), .cmd_code(cmd_code_v[1]),
    .cmd_arg(cmd_arg_v[1]), .cmd_ready(cmd_ready_w[1]), .send_en(send_en_w[1]),
    .date_byte(date_w[1]), .tx_down(tx_w[1]), .busy(busy_w[1]), .frame_done(frame_done_w[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int k, input logic [7:0] c, input logic [7:0] a);
    logic [7:0] b [6];
    b[0] = 8'h7E;
    b[1] = 8'h04;
    b[2] = c;
    b[3] = a;
    b[4] = 8'(8'h04 + c + a);
    b[5] = 8'hEF;
    for (int i = 0; i < 6; i++) begin
      if (k == 0) exp0.push_back(b[i]);
      else        exp1.push_back(b[i]);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_cmd(input int k, input logic [7:0] c, input logic [7:0] a);
    int w = 0;
    cmd_code_v[k]  = c;
    cmd_arg_v[k]   = a;
    cmd_valid_v[k] = 1'b1;
    while (cmd_ready_w[k] !== 1'b1 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_accept_wait", 32'(cmd_ready_w[k]), 32'd1);
    if (cmd_ready_w[k] === 1'b1) push_frame(k, c, a);
    @(negedge clk);
    cmd_valid_v[k] = 1'b0;
  endtask

  task automatic wait_done(input int k);
    int w = 0;
    while ((((k == 0) ? exp0.size() : exp1.size()) != 0 || busy_w[k] !== 1'b0) && w < 20000) begin
      @(negedge clk);
      w++;
    end
    chk("wait_done_timeout", 32'(w < 20000), 32'd1);
  endtask

  // Transmitter model: tx_down pulse 10 cycles after each send_en
  initial begin
    for (int k = 0; k < 2; k++) begin
      tx_model[k] = 1'b0;
      pend[k]     = 0;
      txd_cyc[k]  = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        tx_model[k] = 1'b0;
        if (send_en_w[k] === 1'b1) pend[k] = 10;
        else if (pend[k] > 0) begin
          pend[k]--;
          if (pend[k] == 0) begin
            tx_model[k] = 1'b1;
            txd_cyc[k]  = cyc;
          end
        end
      end
    end
  end

  // Scoreboard monitor: each send_en pops one expected byte
  initial begin
    for (int k = 0; k < 2; k++) begin
      nsend[k]  = 0;
      nframe[k] = 0;
      armed[k]  = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) armed[k] = 1'b0;
        else begin
          if (send_en_w[k] === 1'b1) begin
            nsend[k]++;
            if (k == 0) begin
              chk("byte_expected0", 32'(exp0.size() != 0), 32'd1);
              if (exp0.size() != 0) chk("byte0", 32'(date_w[0]), 32'(exp0.pop_front()));
              if (armed[0] && gap_chk_en) chk("gap20", 32'(cyc - txd_cyc[0]), 32'(GAP + 2));
            end else begin
              chk("byte_expected1", 32'(exp1.size() != 0), 32'd1);
              if (exp1.size() != 0) chk("byte1", 32'(date_w[1]), 32'(exp1.pop_front()));
              if (armed[1]) chk("gap0", 32'(cyc - txd_cyc[1]), 32'd2);
            end
            armed[k] = 1'b0;
          end
          if (frame_done_w[k] === 1'b1) begin
            nframe[k]++;
            chk("frame_done_lat", 32'(cyc - txd_cyc[k]), 32'd1);
            armed[k] = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, f, w;
    for (int k = 0; k < 2; k++) begin
      cmd_valid_v[k] = 1'b0;
      cmd_code_v[k]  = '0;
      cmd_arg_v[k]   = '0;
      spur[k]        = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_send_en",    32'(send_en_w[0]),    32'd0);
    chk("rst_date",       32'(date_w[0]),       32'h00);
    chk("rst_busy",       32'(busy_w[0]),       32'd0);
    chk("rst_frame_done", 32'(frame_done_w[0]), 32'd0);
    chk("rst_cmd_ready",  32'(cmd_ready_w[0]),  32'd1);
    rst = 1'b0;
    @(negedge clk);

    // single command and first-byte latency
    send_cmd(0, 8'h03, 8'h05);
    chk("lat_n_send_en", 32'(send_en_w[0]), 32'd0);
    @(negedge clk);
    chk("lat_n1_send_en", 32'(send_en_w[0]), 32'd1);
    chk("lat_n1_head",    32'(date_w[0]),    32'h7E);
    wait_done(0);
    chk("single_sends",  32'(nsend[0]),  32'd6);
    chk("single_frames", 32'(nframe[0]), 32'd1);

    // checksum wrap
    b = nsend[0];
    send_cmd(0, 8'hFF, 8'hFF);
    wait_done(0);
    chk("wrap_sends", 32'(nsend[0] - b), 32'd6);

    // back-to-back commands held valid, FIFO fills, gap measured
    armed[0]   = 1'b0;
    gap_chk_en = 1'b1;
    b = nsend[0];
    f = nframe[0];
    send_cmd(0, 8'h11, 8'h21);
    send_cmd(0, 8'h12, 8'h22);
    send_cmd(0, 8'h13, 8'h23);
    send_cmd(0, 8'h14, 8'h24);
    send_cmd(0, 8'h15, 8'h25);
    chk("full_ready_low", 32'(cmd_ready_w[0]), 32'd0);
    send_cmd(0, 8'h16, 8'h26);
    wait_done(0);
    gap_chk_en = 1'b0;
    chk("six_sends",  32'(nsend[0] - b),  32'd36);
    chk("six_frames", 32'(nframe[0] - f), 32'd6);

    // spurious tx_down in IDLE, SEND and GAP
    b = nsend[0];
    spur[0] = 1'b1;
    @(negedge clk);
    spur[0] = 1'b0;
    @(negedge clk);
    chk("spur_idle_busy", 32'(busy_w[0]), 32'd0);
    send_cmd(0, 8'h2A, 8'h3B);
    spur[0] = 1'b1;
    @(negedge clk);
    chk("spur_in_send", 32'(send_en_w[0]), 32'd1);
    @(negedge clk);
    spur[0] = 1'b0;
    w = 0;
    while (frame_done_w[0] !== 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("spur_frame_done", 32'(frame_done_w[0]), 32'd1);
    spur[0] = 1'b1;
    @(negedge clk);
    spur[0] = 1'b0;
    chk("spur_gap_busy", 32'(busy_w[0]), 32'd1);
    wait_done(0);
    chk("spur_sends", 32'(nsend[0] - b), 32'd6);

    // reset mid-frame after B2 with two commands queued
    b = nsend[0];
    send_cmd(0, 8'h41, 8'h51);
    send_cmd(0, 8'h42, 8'h52);
    send_cmd(0, 8'h43, 8'h53);
    w = 0;
    while (!(send_en_w[0] === 1'b1 && date_w[0] === 8'h41) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("b2_reached", 32'(date_w[0]), 32'h41);
    @(negedge clk);
    rst = 1'b1;
    exp0.delete();
    #1;
    chk("mid_rst_send_en",    32'(send_en_w[0]),    32'd0);
    chk("mid_rst_date",       32'(date_w[0]),       32'h00);
    chk("mid_rst_busy",       32'(busy_w[0]),       32'd0);
    chk("mid_rst_frame_done", 32'(frame_done_w[0]), 32'd0);
    chk("mid_rst_cmd_ready",  32'(cmd_ready_w[0]),  32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("post_rst_busy",  32'(busy_w[0]),     32'd0);
    chk("post_rst_sends", 32'(nsend[0] - b),  32'd3);
    send_cmd(0, 8'h44, 8'h54);
    @(negedge clk);
    chk("post_rst_send_en", 32'(send_en_w[0]), 32'd1);
    chk("post_rst_head",    32'(date_w[0]),    32'h7E);
    wait_done(0);
    chk("post_rst_frame_sends", 32'(nsend[0] - b), 32'd9);

    // zero-gap instance, two queued commands
    send_cmd(1, 8'h61, 8'h71);
    send_cmd(1, 8'h62, 8'h72);
    wait_done(1);
    chk("g0_sends",  32'(nsend[1]),  32'd12);
    chk("g0_frames", 32'(nframe[1]), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
